// File: rtl/fpnew_f2i_writeback.sv
// fpnew_f2i_writeback: output FIFO behind the FP->int cast unit.
//
// Buffers {result, status, extension bit, tag} so that the cast pipeline is decoupled from
// integer-register writeback back-pressure. in_ready_o depends only on registered state, so
// there is no combinational path from out_ready_i to in_ready_o.
//
// Optional feature: define FPNEW_F2I_WB_FFLAGS_EN to build the sticky fflags accumulator.
// Without it fflags_o is tied to zero and clear_flags_i is ignored.
module fpnew_f2i_writeback #(
  parameter int unsigned DST_WIDTH = 64,
  parameter int unsigned TAG_WIDTH = 1,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Upstream (cast unit) side
  input  logic [DST_WIDTH-1:0] result_i,
  input  logic [4:0]           status_i,
  input  logic                 extension_bit_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  // Control
  input  logic                 flush_i,
  input  logic                 clear_flags_i,
  // Downstream (writeback) side
  output logic [DST_WIDTH-1:0] result_o,
  output logic [4:0]           status_o,
  output logic                 extension_bit_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  // Status
  output logic [4:0]           fflags_o,
  output logic                 busy_o
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth = PtrWidth + 1;

  localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic [DST_WIDTH-1:0] result_mem [DEPTH];
  logic [4:0]           status_mem [DEPTH];
  logic                 ext_mem    [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem    [DEPTH];

  logic push, pop;
  logic full, empty;

  // ---------------------------------------------------------------------------
  // Handshake decode: full/empty come from registered count only
  // ---------------------------------------------------------------------------
  always_comb begin
    full  = (count_q == FullCount);
    empty = (count_q == '0);
    push  = in_valid_i & ~full;
    pop   = out_ready_i & ~empty;
  end

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign busy_o      = ~empty;

  // ---------------------------------------------------------------------------
  // Head-of-queue outputs; don't-care while empty
  // ---------------------------------------------------------------------------
  always_comb begin
    result_o        = result_mem[rd_ptr_q];
    status_o        = status_mem[rd_ptr_q];
    extension_bit_o = ext_mem[rd_ptr_q];
    tag_o           = tag_mem[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Pointer / count next-state; flush discards any handshake in the same cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; data registers need no reset since they are only observed when valid
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      result_mem[wr_ptr_q] <= result_i;
      status_mem[wr_ptr_q] <= status_i;
      ext_mem[wr_ptr_q]    <= extension_bit_i;
      tag_mem[wr_ptr_q]    <= tag_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky exception flags
  // ---------------------------------------------------------------------------
`ifdef FPNEW_F2I_WB_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  // A pop during flush is discarded, so it must not contribute its status
  always_comb begin
    fflags_d = fflags_q;
    if (pop && !flush_i) begin
      fflags_d = (clear_flags_i ? 5'b00000 : fflags_q) | status_o;
    end else if (clear_flags_i) begin
      fflags_d = 5'b00000;
    end
  end

  // Flag register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= 5'b00000;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_clear_flags;
  assign unused_clear_flags = clear_flags_i;
  assign fflags_o           = 5'b00000;
`endif

endmodule

// File: tb/tb_fpnew_f2i_writeback.sv
// Directed scoreboard bench for fpnew_f2i_writeback (DEPTH=2, DST_WIDTH=64, TAG_WIDTH=1).
// Expected entries are queued when a push is driven and compared while at the head.
module tb_fpnew_f2i_writeback;

  localparam int unsigned DstW  = 64;
  localparam int unsigned TagW  = 1;
  localparam int unsigned Depth = 2;
`ifdef FPNEW_F2I_WB_FFLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [DstW-1:0] result_i;
  logic [4:0]      status_i;
  logic            ext_i;
  logic [TagW-1:0] tag_i;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            clear_flags;
  logic [DstW-1:0] result_o;
  logic [4:0]      status_o;
  logic            ext_o;
  logic [TagW-1:0] tag_o;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      fflags;
  logic            busy;

  typedef struct {
    logic [DstW-1:0] result;
    logic [4:0]      status;
    logic            ext;
    logic [TagW-1:0] tag;
  } entry_t;

  entry_t     sb[$];
  logic [4:0] model_flags;
  bit         checking;
  int         n_cmp;
  int         n_err;

  fpnew_f2i_writeback #(
    .DST_WIDTH(DstW),
    .TAG_WIDTH(TagW),
    .DEPTH    (Depth)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .result_i       (result_i),
    .status_i       (status_i),
    .extension_bit_i(ext_i),
    .tag_i          (tag_i),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .flush_i        (flush),
    .clear_flags_i  (clear_flags),
    .result_o       (result_o),
    .status_o       (status_o),
    .extension_bit_o(ext_o),
    .tag_o          (tag_o),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .fflags_o       (fflags),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] r, input logic [4:0] s, input logic t);
    in_valid = v;
    result_i = r;
    status_i = s;
    ext_i    = r[0];
    tag_i    = t;
  endtask

  // Check outputs against the model, advance the model, then cross one rising edge
  task automatic tick();
    bit do_pop, do_push;
    entry_t e;
    if (checking) begin
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("busy", 64'(busy), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() != Depth));
      chk("fflags", 64'(fflags), 64'(model_flags));
      if (sb.size() != 0) begin
        chk("head_result", result_o, sb[0].result);
        chk("head_status", 64'(status_o), 64'(sb[0].status));
        chk("head_ext", 64'(ext_o), 64'(sb[0].ext));
        chk("head_tag", 64'(tag_o), 64'(sb[0].tag));
      end
    end
    do_pop  = (sb.size() != 0) && out_ready;
    do_push = in_valid && (sb.size() != Depth);
    if (rst) begin
      sb.delete();
      model_flags = 5'b0;
    end else if (flush) begin
      sb.delete();
      if (FlagsEn && clear_flags) model_flags = 5'b0;
    end else begin
      if (do_pop) begin
        if (FlagsEn) model_flags = (clear_flags ? 5'b0 : model_flags) | sb[0].status;
        void'(sb.pop_front());
      end else if (FlagsEn && clear_flags) begin
        model_flags = 5'b0;
      end
      if (do_push) begin
        e.result = result_i;
        e.status = status_i;
        e.ext    = ext_i;
        e.tag    = tag_i;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    checking    = 0;
    model_flags = 5'b0;
    rst         = 1'b1;
    flush       = 1'b0;
    clear_flags = 1'b0;
    out_ready   = 1'b0;
    drive(0, 64'h0, 5'b0, 1'b0);
    tick();
    tick();
    rst      = 1'b0;
    checking = 1;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    tick();

    // Single entry, NV status
    out_ready = 1'b1;
    drive(1, 64'h7FFF_FFFF, 5'b10000, 1'b1);
    tick();
    drive(0, 64'h0, 5'b0, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_result", result_o, 64'h7FFF_FFFF);
    tick();
    chk("single_fflags", 64'(fflags), FlagsEn ? 64'b10000 : 64'd0);
    tick();

    // Fill to full, hold off third push, then drain in order
    out_ready = 1'b0;
    drive(1, 64'd1, 5'b0, 1'b0);
    tick();
    drive(1, 64'd2, 5'b0, 1'b1);
    tick();
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    drive(1, 64'd3, 5'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    chk("fill_head_a", result_o, 64'd1);
    tick();
    chk("fill_head_b", result_o, 64'd2);
    tick();
    drive(0, 64'h0, 5'b0, 1'b0);
    chk("fill_head_c", result_o, 64'd3);
    tick();
    tick();

    // Streaming 0..15 with continuous valid/ready
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 64'(i), 5'b0, 1'(i));
      tick();
    end
    drive(0, 64'h0, 5'b0, 1'b0);
    tick();
    tick();

    // Flush with two entries buffered and a concurrent pop
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    out_ready   = 1'b0;
    drive(1, 64'hA0, 5'b00001, 1'b0);
    tick();
    drive(1, 64'hA1, 5'b00100, 1'b1);
    tick();
    drive(0, 64'h0, 5'b0, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_fflags", 64'(fflags), 64'd0);
    tick();

    // Flag accumulation, then clear together with a pop
    drive(1, 64'hB0, 5'b00001, 1'b0);
    tick();
    drive(1, 64'hB1, 5'b00100, 1'b1);
    tick();
    drive(0, 64'h0, 5'b0, 1'b0);
    tick();
    chk("flags_nx_of", 64'(fflags), FlagsEn ? 64'b00101 : 64'd0);
    drive(1, 64'hB2, 5'b00010, 1'b0);
    tick();
    drive(0, 64'h0, 5'b0, 1'b0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("flags_clear_uf", 64'(fflags), FlagsEn ? 64'b00010 : 64'd0);
    tick();

    // Reset while full with both handshakes asserted
    out_ready = 1'b0;
    drive(1, 64'hC0, 5'b01000, 1'b1);
    tick();
    drive(1, 64'hC1, 5'b10000, 1'b0);
    tick();
    drive(1, 64'hC2, 5'b00001, 1'b1);
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 64'h0, 5'b0, 1'b0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_fflags", 64'(fflags), 64'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
